// File: rtl/div8_pkg.sv
// div8 shared types and constants.
// DIV8_DBZ_EN (optional) enables early divide-by-zero exit in div8_ctrl.
package div8_pkg;

   localparam int DIV_WIDTH = 8;
   localparam int ITER_W    = $clog2(DIV_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CALC = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/div8_iter_cnt.sv
// div8 iteration counter.
// Loadable down-counter that parks at zero and flags it.
module div8_iter_cnt
   import div8_pkg::*;
#(
   parameter int W = ITER_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] ld_val,
   output logic [W-1:0] cnt,
   output logic         zero
);

   // load wins over decrement; never wraps below zero
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= ld_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/div8_ctrl.sv
// div8 restoring divider sequencing controller.
// DIV8_DBZ_EN: when defined, a zero divisor exits LOAD straight to DONE with err.
module div8_ctrl
   import div8_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     dvsr_zero,
   input  logic                     borrow,
   output logic                     ld_en,
   output logic                     sh_en,
   output logic                     keep_sel,
   output logic                     q_bit,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [$clog2(WIDTH)-1:0] iter
);

   localparam int IW = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'(ST_IDLE);
   localparam logic [1:0] LOAD = 2'(ST_LOAD);
   localparam logic [1:0] CALC = 2'(ST_CALC);
   localparam logic [1:0] DONE = 2'(ST_DONE);

   logic [1:0] state;
   logic [1:0] nxt;
   logic       cnt_zero;

   // next-state: start only honoured in IDLE and DONE
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: if (start) nxt = LOAD;
         LOAD: begin
            nxt = CALC;
`ifdef DIV8_DBZ_EN
            if (dvsr_zero) nxt = DONE;
`endif
         end
         CALC: if (cnt_zero) nxt = DONE;
         DONE: nxt = start ? LOAD : IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= nxt;
   end

   // iter holds WIDTH-1 on the first CALC cycle, 0 on the last
   div8_iter_cnt #(
      .W (IW)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .load   (state == LOAD),
      .dec    (state == CALC),
      .ld_val (IW'(WIDTH - 1)),
      .cnt    (iter),
      .zero   (cnt_zero)
   );

`ifdef DIV8_DBZ_EN
   // err cleared entering LOAD, captured entering DONE
   always_ff @(posedge clk) begin
      if (rst)
         err <= 1'b0;
      else if (nxt == LOAD && state != LOAD)
         err <= 1'b0;
      else if (state == LOAD && nxt == DONE)
         err <= dvsr_zero;
   end
`else
   logic unused_dz;
   assign unused_dz = dvsr_zero;
   assign err       = 1'b0;
`endif

   assign ld_en    = (state == LOAD);
   assign sh_en    = (state == CALC);
   assign busy     = (state == LOAD) || (state == CALC);
   assign done     = (state == DONE);
   assign keep_sel = (state == CALC) && !borrow;
   assign q_bit    = (state == CALC) && !borrow;

endmodule

// File: tb/tb_div8_ctrl.sv
// div8_ctrl self-checking bench.
// Cycle k = period in which start is sampled at its closing edge (k=0 starts).
module tb_div8_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       dvsr_zero = 1'b0;
   logic       borrow = 1'b0;
   logic       ld_en, sh_en, keep_sel, q_bit, busy, done, err;
   logic [2:0] iter;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div8_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dvsr_zero (dvsr_zero),
      .borrow    (borrow),
      .ld_en     (ld_en),
      .sh_en     (sh_en),
      .keep_sel  (keep_sel),
      .q_bit     (q_bit),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .iter      (iter)
   );

   // per-cycle bitmaps: bit k = value in cycle k
   typedef struct {
      string       name;
      logic [31:0] st;
      logic [31:0] bw;
      logic [31:0] rs;
      logic        dz;
      logic [31:0] ld;
      logic [31:0] sh;
      logic [31:0] q;
      logic [31:0] bz;
      logic [31:0] dn;
      logic [31:0] er;
   } vec_t;

   vec_t       tbl[5];
   logic [6:0] sbq[$];

   function automatic logic [6:0] outs();
      return {ld_en, sh_en, keep_sel, q_bit, busy, done, err};
   endfunction

   task automatic cmp(input string nm, input int k,
                      input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %b want %b (ld sh ks q busy done err)",
                  nm, k, act, exp);
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic run(input vec_t v, input int n);
      for (int k = 0; k < n; k++) begin
         start     = v.st[k];
         borrow    = v.bw[k];
         rst       = v.rs[k];
         dvsr_zero = v.dz;
         sbq.push_back({v.ld[k], v.sh[k], v.q[k], v.q[k],
                        v.bz[k], v.dn[k], v.er[k]});
         @(negedge clk);
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s cycle %0d: scoreboard empty", v.name, k);
         end else begin
            cmp(v.name, k, outs(), sbq.pop_front());
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
   endtask

   initial begin
      tbl[0] = '{"nominal", 32'h1, 32'h12C, 32'h0, 1'b0,
                 32'h2, 32'h3FC, 32'h2D0, 32'h3FE, 32'h400, 32'h0};
      tbl[1] = '{"busy_start", 32'h21, 32'h12C, 32'h0, 1'b0,
                 32'h2, 32'h3FC, 32'h2D0, 32'h3FE, 32'h400, 32'h0};
      tbl[2] = '{"back2back", 32'hFFFFFF, 32'h0, 32'h0, 1'b0,
                 32'h200802, 32'hCFF3FC, 32'hCFF3FC, 32'hEFFBFE,
                 32'h100400, 32'h0};
      tbl[3] = '{"rst_mid", 32'h1, 32'h12C, 32'h40, 1'b0,
                 32'h2, 32'h7C, 32'h50, 32'h7E, 32'h0, 32'h0};
`ifdef DIV8_DBZ_EN
      tbl[4] = '{"div_zero", 32'h1, 32'h0, 32'h0, 1'b1,
                 32'h2, 32'h0, 32'h0, 32'h2, 32'h4, 32'hFFFFFC};
`else
      tbl[4] = '{"div_zero", 32'h1, 32'h0, 32'h0, 1'b1,
                 32'h2, 32'h3FC, 32'h3FC, 32'h3FE, 32'h400, 32'h0};
`endif

      // reset held 2 cycles with start high: nothing happens
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      cmp("rst_hold1", 1, outs(), 7'b0);
      cmp("rst_iter", 1, {4'b0, iter}, 7'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      cmp("rst_hold2", 2, outs(), 7'b0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      cmp("ld_after_rst", 3, outs(), 7'b1000100);

      for (int i = 0; i < 5; i++) begin
         do_reset();
         run(tbl[i], 24);
      end

      // iter walks WIDTH-1 down to 0 across CALC
      do_reset();
      for (int k = 0; k < 12; k++) begin
         start  = (k == 0);
         borrow = 1'b0;
         @(negedge clk);
         if (k >= 2 && k <= 9)
            cmp("iter", k, {4'b0, iter}, 7'(9 - k));
         @(posedge clk); #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div8_ctrl.md
# div8_ctrl

Sequencing controller for the 8-bit unsigned restoring (shift-subtract) divider. It accepts a start request, generates the load, shift, and restore/keep select strobes that steer the datapath muxes and registers for WIDTH iterations, and reports completion. It sits between the divider's requester and the quotient/remainder datapath. It consumes only two status flags from that datapath: divisor-zero and subtraction borrow.

## Interface
Parameters:
- WIDTH, 8, operand width and number of iterations (≥2)

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a division; sampled in IDLE and DONE only
- dvsr_zero  in  1  datapath flag: divisor register equals 0 (valid in LOAD and later)
- borrow  in  1  datapath flag: current trial subtraction (partial remainder − divisor) is negative
- ld_en  out  1  load dividend/divisor into datapath; clear partial remainder
- sh_en  out  1  shift {remainder, quotient} left by one and write the selected remainder
- keep_sel  out  1  remainder mux select: 1 = take difference, 0 = restore (take shifted remainder)
- q_bit  out  1  quotient bit shifted in this cycle
- busy  out  1  high from LOAD through last CALC cycle
- done  out  1  one-cycle pulse; datapath results valid from this cycle until next ld_en
- err  out  1  divide-by-zero flag (see Configuration); valid with done
- iter  out  $clog2(WIDTH)  current iteration index, debug/visibility

## Operation
- States: IDLE, LOAD, CALC, DONE.
- IDLE: all strobes 0. If start=1, go to LOAD.
- LOAD: ld_en=1, busy=1, iter loaded with WIDTH−1, then go to CALC.
- CALC: busy=1, sh_en=1, keep_sel=~borrow, q_bit=~borrow.
  - keep_sel and q_bit are combinational from borrow in the same cycle.
  - iter decrements each cycle. When iter==0, go to DONE; otherwise stay in CALC.
  - CALC lasts exactly WIDTH cycles.
- DONE: done=1 for one cycle.
  - If start=1, go directly to LOAD (back-to-back operation).
  - Otherwise go to IDLE.
- start in LOAD or CALC is ignored. It is not queued.
- err is registered and set at DONE entry. It is cleared on entry to LOAD and by rst.
- Reset values: state=IDLE, ld_en=sh_en=keep_sel=q_bit=busy=done=err=0, iter=0.
- rst asserted mid-operation: returns to IDLE on the next edge. No done is generated, and datapath contents are don't-care.
- Outputs other than keep_sel and q_bit are decoded from state and registers only. They have no input-to-output combinational path.

## Timing
- Define cycle 0 as the edge where start is sampled high in IDLE.
- LOAD is active in cycle 1.
- CALC is active in cycles 2 .. WIDTH+1.
- done is high in cycle WIDTH+2, which is cycle 10 for WIDTH=8.
- Throughput with start held high: one result every WIDTH+2 cycles.
- borrow must settle within the same CALC cycle, because the datapath subtraction is combinational.

## Configuration
- Macro DIV8_DBZ_EN.
- Defined:
  - In LOAD, if dvsr_zero=1, go to DONE next, skipping CALC. Done appears in cycle 2 with err=1.
  - sh_en is never asserted for that operation.
- Undefined:
  - dvsr_zero is ignored and err is tied to 0.
  - A zero divisor runs the full WIDTH iterations. The result is quotient 2^WIDTH−1 and remainder equal to the dividend, which is the natural restoring result.

## Structure
- Shared package div8_pkg contains:
  - the state enum (IDLE, LOAD, CALC, DONE);
  - the WIDTH default constant;
  - the ITER_W = $clog2(WIDTH) constant.
- One sub-module, div8_iter_cnt: a loadable down-counter with a zero flag, used for iter.
- The FSM and output decode stay in div8_ctrl.

## Test plan
- Reset, then idle: hold rst for 2 cycles with start=1. Expect all outputs 0 and no LOAD. After rst drops with start=1, expect ld_en in the next cycle.
- Nominal sequence: pulse start; tie borrow to the pattern 1,1,0,1,0,0,1,0 across the CALC cycles.
  - Expect ld_en in cycle 1.
  - Expect sh_en in cycles 2–9 with q_bit sequence 0,0,1,0,1,1,0,1.
  - Expect done only in cycle 10 and busy in cycles 1–9.
- Start while busy: assert start again in cycle 5. Expect no effect: done in cycle 10 only, and exactly one LOAD.
- Back-to-back: hold start high continuously. Expect ld_en in cycles 1 and 11, and done in cycles 10 and 20.
- Divide-by-zero: set dvsr_zero=1.
  - With DIV8_DBZ_EN defined, expect done and err in cycle 2 and no sh_en.
  - Without it, expect done in cycle 10 with err=0.
- Reset mid-operation: assert rst in cycle 6. Expect IDLE and all outputs 0 next cycle, and no done for the aborted operation.
